// File: rtl/render_pkg.sv
// Shared definitions for the renderer frame-buffer write path.
// Holds the 3D-region screen window, the cylinder-region correction,
// frame-buffer geometry, the writer FSM state type and the RGB packer.
package render_pkg;

  localparam int unsigned START_X       = 340;
  localparam int unsigned START_Y       = 390;
  localparam int unsigned END_X         = 684;
  localparam int unsigned END_Y         = 765;
  localparam int unsigned REGION_DIVIDE = 530;
  localparam int unsigned CYL_SHIFT     = 2;

  localparam int unsigned FB_WIDTH = END_X - START_X;
  localparam int unsigned FB_DEPTH = 129000;

  localparam int unsigned PIX_IN_W  = 24;
  localparam int unsigned PIX_OUT_W = 12;
  localparam int unsigned HCOUNT_W  = 11;
  localparam int unsigned VCOUNT_W  = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } fb_state_t;

  // RGB888 -> RGB444 keeping the top nibble of each channel.
  function automatic logic [PIX_OUT_W-1:0] pack_rgb444(input logic [PIX_IN_W-1:0] d);
    return {d[23:20], d[15:12], d[7:4]};
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Two-stage pixel-to-frame-buffer address pipeline.
// Stage 1: range check, cylinder column shift, row-offset multiply, packing.
// Stage 2: column + row offset sum, drives the BRAM write port.
// Ports:
//   clk, rst            clock, async active-high reset
//   valid_in            a beat is present on hcount_in/vcount_in/data_in
//   hcount_in/vcount_in screen coordinates of the beat
//   data_in             RGB888 pixel
//   addr_out/data_out   frame-buffer write address / packed pixel (held between writes)
//   we_out              write enable, high for beats that were kept
//   range_err_out       one-cycle pulse for a beat outside the 3D region
module fb_addr_calc #(
  parameter int unsigned START_X       = render_pkg::START_X,
  parameter int unsigned START_Y       = render_pkg::START_Y,
  parameter int unsigned END_X         = render_pkg::END_X,
  parameter int unsigned END_Y         = render_pkg::END_Y,
  parameter int unsigned REGION_DIVIDE = render_pkg::REGION_DIVIDE,
  parameter int unsigned CYL_SHIFT     = render_pkg::CYL_SHIFT,
  parameter int unsigned ADDR_W        = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic [23:0]       data_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [11:0]       data_out,
  output logic              we_out,
  output logic              range_err_out
);
  import render_pkg::*;

  localparam int unsigned ROW_PITCH = END_X - START_X;

  logic              in_range_c;
  logic              keep_c;
  logic [11:0]       shift_c;
  logic [11:0]       col_c;      // two's complement column, bit 11 = negative
  logic [ADDR_W-1:0] row_off_c;

  logic              s1_keep;
  logic [10:0]       s1_col;
  logic [ADDR_W-1:0] s1_row_off;
  logic [11:0]       s1_pix;

  // Stage-1 combinational: window check, column correction, row offset.
  always_comb begin
    in_range_c = (hcount_in >= 11'(START_X)) && (hcount_in < 11'(END_X)) &&
                 (vcount_in >= 10'(START_Y)) && (vcount_in < 10'(END_Y));
    shift_c    = (vcount_in < 10'(REGION_DIVIDE)) ? 12'(CYL_SHIFT) : 12'd0;
    col_c      = 12'(hcount_in) - 12'(START_X) - shift_c;
    // Negative columns come from renderer skew and are dropped without error.
    keep_c     = valid_in && in_range_c && !col_c[11];
    row_off_c  = ADDR_W'(vcount_in - 10'(START_Y)) * ADDR_W'(ROW_PITCH);
  end

  // Stage 1 registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_keep       <= 1'b0;
      s1_col        <= '0;
      s1_row_off    <= '0;
      s1_pix        <= '0;
      range_err_out <= 1'b0;
    end else begin
      s1_keep       <= keep_c;
      s1_col        <= col_c[10:0];
      s1_row_off    <= row_off_c;
      s1_pix        <= pack_rgb444(data_in);
      range_err_out <= valid_in && !in_range_c;
    end
  end

  // Stage 2: address sum onto the write port; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_out <= '0;
      data_out <= '0;
      we_out   <= 1'b0;
    end else begin
      we_out <= s1_keep;
      if (s1_keep) begin
        addr_out <= ADDR_W'(s1_col) + s1_row_off;
        data_out <= s1_pix;
      end
    end
  end

endmodule

// File: rtl/render_fb_writer.sv
// Consumer end of the renderer pixel stream: captures one armed frame of
// beats, maps them into the frame buffer and reports frame completion.
// Ports:
//   clk_in, rst_in              pixel clock, async active-high reset
//   pixel_axis_tdata/tvalid     RGB888 beat and its valid
//   pixel_axis_tready           high while capturing a frame
//   hcount_in, vcount_in        screen coordinates of the current beat
//   frame_start_in              pulse that arms one frame (ignored unless idle)
//   fb_addr_out/data_out/we_out frame-buffer BRAM write port
//   busy_out                    capturing or draining
//   frame_done_out              pulse once the last write of the frame is out
//   write_count_out             writes issued in the last completed frame
//   range_err_out               sticky out-of-region flag, cleared by reset
module render_fb_writer #(
  parameter int unsigned START_X       = render_pkg::START_X,
  parameter int unsigned START_Y       = render_pkg::START_Y,
  parameter int unsigned END_X         = render_pkg::END_X,
  parameter int unsigned END_Y         = render_pkg::END_Y,
  parameter int unsigned REGION_DIVIDE = render_pkg::REGION_DIVIDE,
  parameter int unsigned CYL_SHIFT     = render_pkg::CYL_SHIFT,
  parameter int unsigned ADDR_W        = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [23:0]       pixel_axis_tdata,
  input  logic              pixel_axis_tvalid,
  output logic              pixel_axis_tready,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              frame_start_in,
  output logic [ADDR_W-1:0] fb_addr_out,
  output logic [11:0]       fb_data_out,
  output logic              fb_we_out,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic [ADDR_W-1:0] write_count_out,
  output logic              range_err_out
);
  import render_pkg::*;

  localparam logic [ADDR_W-1:0] COUNT_MAX = '1;
  localparam logic [1:0]        DRAIN_LAST = 2'd2;

  fb_state_t         state;
  fb_state_t         next_state;
  logic [1:0]        drain_cnt;
  logic [1:0]        drain_cnt_next;
  logic              done_next;
  logic              clear_count_c;
  logic              accept_c;
  logic              last_c;

  logic              beat_valid;
  logic [10:0]       beat_h;
  logic [9:0]        beat_v;
  logic [23:0]       beat_data;

  logic [ADDR_W-1:0] write_cnt;
  logic [ADDR_W-1:0] write_cnt_next;
  logic              calc_err;

  assign accept_c = pixel_axis_tvalid && pixel_axis_tready;
  assign last_c   = (hcount_in == 11'(END_X - 1)) && (vcount_in == 10'(END_Y - 1));

  // Next-state logic; DRAIN lets the final beat clear the pipeline.
  always_comb begin
    next_state     = state;
    drain_cnt_next = drain_cnt;
    done_next      = 1'b0;
    clear_count_c  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start_in) begin
          next_state    = CAPTURE;
          clear_count_c = 1'b1;
        end
      end
      CAPTURE: begin
        if (accept_c && last_c) begin
          next_state     = DRAIN;
          drain_cnt_next = 2'd0;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          next_state = IDLE;
          done_next  = 1'b1;
        end else begin
          drain_cnt_next = drain_cnt + 2'd1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Saturating count of issued writes.
  always_comb begin
    write_cnt_next = write_cnt;
    if (clear_count_c) begin
      write_cnt_next = '0;
    end else if (fb_we_out && (write_cnt != COUNT_MAX)) begin
      write_cnt_next = write_cnt + ADDR_W'(1);
    end
  end

  // State, status outputs and counters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= IDLE;
      drain_cnt         <= 2'd0;
      pixel_axis_tready <= 1'b0;
      busy_out          <= 1'b0;
      frame_done_out    <= 1'b0;
      write_cnt         <= '0;
      write_count_out   <= '0;
      range_err_out     <= 1'b0;
    end else begin
      state             <= next_state;
      drain_cnt         <= drain_cnt_next;
      pixel_axis_tready <= (next_state == CAPTURE);
      busy_out          <= (next_state != IDLE);
      frame_done_out    <= done_next;
      write_cnt         <= write_cnt_next;
      if (done_next) begin
        write_count_out <= write_cnt_next;
      end
      range_err_out     <= range_err_out | calc_err;
    end
  end

  // Accepted beat register feeding the address pipeline.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      beat_valid <= 1'b0;
      beat_h     <= '0;
      beat_v     <= '0;
      beat_data  <= '0;
    end else begin
      beat_valid <= accept_c;
      if (accept_c) begin
        beat_h    <= hcount_in;
        beat_v    <= vcount_in;
        beat_data <= pixel_axis_tdata;
      end
    end
  end

  fb_addr_calc #(
    .START_X       (START_X),
    .START_Y       (START_Y),
    .END_X         (END_X),
    .END_Y         (END_Y),
    .REGION_DIVIDE (REGION_DIVIDE),
    .CYL_SHIFT     (CYL_SHIFT),
    .ADDR_W        (ADDR_W)
  ) u_addr_calc (
    .clk           (clk_in),
    .rst           (rst_in),
    .valid_in      (beat_valid),
    .hcount_in     (beat_h),
    .vcount_in     (beat_v),
    .data_in       (beat_data),
    .addr_out      (fb_addr_out),
    .data_out      (fb_data_out),
    .we_out        (fb_we_out),
    .range_err_out (calc_err)
  );

endmodule

// File: tb/tb_render_fb_writer.sv
// Bench for render_fb_writer: directed beats, a reduced random-gap raster,
// and an asynchronous reset with beats in flight.
module tb_render_fb_writer;

  logic        clk_in;
  logic        rst_in;
  logic [23:0] pixel_axis_tdata;
  logic        pixel_axis_tvalid;
  logic        pixel_axis_tready;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        frame_start_in;
  logic [16:0] fb_addr_out;
  logic [11:0] fb_data_out;
  logic        fb_we_out;
  logic        busy_out;
  logic        frame_done_out;
  logic [16:0] write_count_out;
  logic        range_err_out;

  render_fb_writer dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .pixel_axis_tdata  (pixel_axis_tdata),
    .pixel_axis_tvalid (pixel_axis_tvalid),
    .pixel_axis_tready (pixel_axis_tready),
    .hcount_in         (hcount_in),
    .vcount_in         (vcount_in),
    .frame_start_in    (frame_start_in),
    .fb_addr_out       (fb_addr_out),
    .fb_data_out       (fb_data_out),
    .fb_we_out         (fb_we_out),
    .busy_out          (busy_out),
    .frame_done_out    (frame_done_out),
    .write_count_out   (write_count_out),
    .range_err_out     (range_err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int due;
    int addr;
    int data;
  } wr_t;

  wr_t q[$];
  bit  m_armed = 0;
  int  m_err_at = -1;
  int  m_done_at = -1;
  int  m_cnt = 0;
  int  m_wc = 0;
  int  mh, mv, mcol;
  int  last_addr = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: what each accepted beat must produce, and when.
  always @(posedge clk_in) begin
    cyc++;
    if (rst_in) begin
      m_armed   = 0;
      m_err_at  = -1;
      m_done_at = -1;
      m_cnt     = 0;
      m_wc      = 0;
      q.delete();
    end else begin
      if (cyc == m_done_at) m_wc = m_cnt;
      if (m_armed && pixel_axis_tvalid) begin
        mh = int'(hcount_in);
        mv = int'(vcount_in);
        if (mh < 340 || mh >= 684 || mv < 390 || mv >= 765) begin
          if (m_err_at < 0) m_err_at = cyc + 2;
        end else begin
          mcol = mh - 340 - ((mv < 530) ? 2 : 0);
          if (mcol >= 0) begin
            q.push_back('{cyc + 2, mcol + (mv - 390) * 344,
                          int'({pixel_axis_tdata[23:20], pixel_axis_tdata[15:12], pixel_axis_tdata[7:4]})});
            m_cnt++;
          end
        end
        if (mh == 683 && mv == 764) begin
          m_armed   = 0;
          m_done_at = cyc + 3;
        end
      end else if (!m_armed && !(m_done_at >= 0 && cyc <= m_done_at) && frame_start_in) begin
        m_armed = 1;
        m_cnt   = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk_in) begin
    if (rst_in) begin
      chk("rst_ctrl", {27'd0, pixel_axis_tready, fb_we_out, busy_out, frame_done_out, range_err_out}, 0);
      chk("rst_addr", 32'(fb_addr_out), 0);
      chk("rst_data", 32'(fb_data_out), 0);
      chk("rst_wcount", 32'(write_count_out), 0);
    end else begin
      while (q.size() > 0 && q[0].due < cyc) begin
        chk("write_missing", 0, 1);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("we", 32'(fb_we_out), 1);
        chk("addr", 32'(fb_addr_out), q[0].addr);
        chk("data", 32'(fb_data_out), q[0].data);
        void'(q.pop_front());
      end else begin
        chk("we_idle", 32'(fb_we_out), 0);
      end
      chk("tready", 32'(pixel_axis_tready), 32'(m_armed));
      chk("busy", 32'(busy_out), 32'(m_armed || (m_done_at >= 0 && cyc < m_done_at)));
      chk("frame_done", 32'(frame_done_out), 32'(cyc == m_done_at));
      chk("write_count", 32'(write_count_out), m_wc);
      chk("range_err", 32'(range_err_out), 32'(m_err_at >= 0 && cyc >= m_err_at));
      if (fb_we_out === 1'b1) last_addr = int'(fb_addr_out);
    end
  end

  // Present one beat starting at a negedge; returns at the negedge after acceptance.
  task automatic send_beat(input int h, input int v, input logic [23:0] d, input bit gaps);
    bit ok;
    bit rdy;
    int gap;
    ok  = 0;
    gap = gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (gap) @(negedge clk_in);
    pixel_axis_tvalid = 1'b1;
    hcount_in         = 11'(h);
    vcount_in         = 10'(v);
    pixel_axis_tdata  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      rdy = pixel_axis_tready;
      @(posedge clk_in);
      ok = rdy;
      @(negedge clk_in);
    end
    pixel_axis_tvalid = 1'b0;
    if (!ok) chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    frame_start_in = 1'b1;
    @(negedge clk_in);
    frame_start_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_in            = 1'b1;
    pixel_axis_tdata  = '0;
    pixel_axis_tvalid = 1'b0;
    hcount_in         = '0;
    vcount_in         = '0;
    frame_start_in    = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("reset_tready", 32'(pixel_axis_tready), 0);
    chk("reset_busy", 32'(busy_out), 0);
    rst_in = 1'b0;

    // Valid before arming must not be accepted.
    pixel_axis_tvalid = 1'b1;
    hcount_in         = 11'd342;
    vcount_in         = 10'd390;
    pixel_axis_tdata  = 24'hF0A05C;
    repeat (3) @(negedge clk_in);
    chk("pre_arm_tready", 32'(pixel_axis_tready), 0);
    chk("pre_arm_we", 32'(fb_we_out), 0);

    // Arm; the waiting beat is accepted on the following edge.
    pulse_start();
    chk("armed_tready", 32'(pixel_axis_tready), 1);
    @(negedge clk_in);
    pixel_axis_tvalid = 1'b0;
    chk("lat_we_edge1", 32'(fb_we_out), 0);
    @(negedge clk_in);
    chk("lat_we_edge2", 32'(fb_we_out), 0);
    @(negedge clk_in);
    chk("lat_we_edge3", 32'(fb_we_out), 1);
    chk("first_addr", 32'(fb_addr_out), 0);
    chk("first_data", 32'(fb_data_out), 32'h0FA5);

    // Skewed column in the cylinder region: silent drop.
    send_beat(340, 390, 24'h123456, 0);
    repeat (3) @(negedge clk_in);
    chk("skew_no_err", 32'(range_err_out), 0);

    // Divide row itself is outside the cylinder region: no shift.
    send_beat(340, 530, 24'hABCDEF, 0);
    repeat (2) @(negedge clk_in);
    chk("divide_we", 32'(fb_we_out), 1);
    chk("divide_addr", 32'(fb_addr_out), 48160);
    chk("divide_data", 32'(fb_data_out), 32'h0ACE);

    // Out-of-region beat sets the sticky error; a re-arm mid-capture is ignored.
    send_beat(700, 400, 24'hFFFFFF, 0);
    repeat (3) @(negedge clk_in);
    chk("range_err_set", 32'(range_err_out), 1);
    pulse_start();
    chk("restart_ignored_busy", 32'(busy_out), 1);
    chk("restart_ignored_tready", 32'(pixel_axis_tready), 1);

    // Bottom rows of the raster with random valid gaps, ending on the last pixel.
    for (int v = 760; v < 765; v++) begin
      for (int h = 340; h < 684; h++) begin
        send_beat(h, v, 24'(($urandom() & 32'hFFFFFF)), 1);
      end
    end
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (frame_done_out === 1'b1) seen = 1;
      else @(negedge clk_in);
    end
    chk("frame_done_seen", 32'(seen), 1);
    chk("final_write_count", 32'(write_count_out), 1722);
    chk("final_last_addr", 32'(last_addr), 128999);
    chk("final_busy", 32'(busy_out), 0);
    @(negedge clk_in);
    chk("post_frame_tready", 32'(pixel_axis_tready), 0);
    chk("post_frame_err_held", 32'(range_err_out), 1);
    chk("post_frame_done_low", 32'(frame_done_out), 0);

    // Asynchronous reset with two beats in flight.
    pulse_start();
    send_beat(400, 600, 24'h112233, 0);
    send_beat(401, 600, 24'h445566, 0);
    #2 rst_in = 1'b1;
    #1;
    chk("async_rst_we", 32'(fb_we_out), 0);
    chk("async_rst_addr", 32'(fb_addr_out), 0);
    chk("async_rst_data", 32'(fb_data_out), 0);
    chk("async_rst_tready", 32'(pixel_axis_tready), 0);
    chk("async_rst_busy", 32'(busy_out), 0);
    chk("async_rst_err", 32'(range_err_out), 0);
    chk("async_rst_wcount", 32'(write_count_out), 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (6) @(negedge clk_in);
    chk("post_rst_err", 32'(range_err_out), 0);
    chk("post_rst_busy", 32'(busy_out), 0);
    chk("post_rst_tready", 32'(pixel_axis_tready), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
